ps2_receiver: RTL and testbench

Deserialises the PS/2 keyboard line (ps2_clk/ps2_data) into scan-code bytes, checks each frame, buffers good bytes in a small FIFO and hands them out one by one as a single-cycle `ready` strobe with `data`. Sits directly upstream of `key_processor`, which samples `data` in any cycle where `ready` is high.

---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_fifo.sv | 89 ++++++++
 rtl/ps2_receiver.sv | 237 +++++++++++++++++++++++
 tb/tb_ps2_receiver.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
//
// Purpose : Definitions shared by the PS/2 receive path and the downstream
//           key_processor. It holds the frame length, the two scan-code
//           prefixes the decoder keys on, the receive FSM state type and a
//           small parity helper.
//
// Contents:
//   PS2_FRAME_BITS  number of ps2_clk falling edges in one frame
//   PS2_BREAK_CODE  prefix byte that marks a key release
//   PS2_EXT_CODE    prefix byte that marks an extended key
//   rx_state_t      receive FSM states (idle / receiving)
//   oddParityOk()   true when a data+parity vector has an odd count of ones
// ---------------------------------------------------------------------------
package ps2_pkg;

  localparam int         PS2_FRAME_BITS = 11;
  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;

  // The FSM only has to know whether a start bit has been seen. The bit
  // counter tracks how far into the frame it is.
  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_RECV = 1'b1
  } rx_state_t;

  // PS/2 uses odd parity over the 8 data bits plus the parity bit, so the
  // XOR of all nine bits is 1 for a good frame.
  function automatic logic oddParityOk(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// ---------------------------------------------------------------------------
// ps2_fifo
//
// Purpose : Small circular byte buffer between the PS/2 frame checker and
//           the output strobe stage. A push into a full buffer is refused
//           unless a pop happens in the same cycle, so queued bytes are
//           never overwritten.
//
// Parameters:
//   DEPTH   number of entries, power of two, at least 2
//   WIDTH   entry width in bits
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   i_push    write i_din this cycle (ignored when full and not popping)
//   i_pop     discard the head entry this cycle (ignored when empty)
//   i_din     write data
//   o_dout    head entry, valid whenever o_empty is low
//   o_full    buffer holds DEPTH entries
//   o_empty   buffer holds no entries
// ---------------------------------------------------------------------------
module ps2_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_dout  = r_mem[r_rdPtr];

  // A pop frees a slot in the same cycle, so a push into a full buffer is
  // still accepted when it is paired with a real pop.
  assign w_doPop  = i_pop & ~o_empty;
  assign w_doPush = i_push & (~o_full | w_doPop);

  // Storage needs no reset: an entry is only ever read after it has been
  // written.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. The count is
  // one bit wider than the pointers so that full and empty can be told apart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_receiver.sv
// ---------------------------------------------------------------------------
// ps2_receiver
//
// Purpose : Turns the raw PS/2 keyboard line into scan-code bytes. Both pins
//           are synchronised and ps2_clk falling edges are detected. The
//           receive FSM collects the 11-bit frame, and the checker validates
//           the stop and parity bits. Good bytes are queued in ps2_fifo and
//           handed out one at a time as a single-cycle ready strobe.
//
// Parameters:
//   FIFO_DEPTH      byte buffer entries, power of two, at least 2
//   TIMEOUT_CYCLES  clk cycles without a ps2_clk fall before a partial
//                   frame is abandoned
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   ps2_clk     raw PS/2 clock, asynchronous
//   ps2_data    raw PS/2 data, asynchronous
//   ready       one-cycle strobe: data holds a new byte
//   data        scan-code byte, held between strobes
//   overflow    one-cycle pulse: good byte dropped, buffer full
//   parity_err  one-cycle pulse: frame dropped for bad odd parity
//   frame_err   one-cycle pulse: frame dropped for bad stop bit or timeout
// ---------------------------------------------------------------------------
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ready,
  output logic [7:0] data,
  output logic       overflow,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int              TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  logic [1:0]      r_clkSync;
  logic [1:0]      r_dataSync;
  logic            r_clkHist;
  logic            w_fall;
  logic            w_dataBit;

  rx_state_t       r_state;
  rx_state_t       w_nextState;
  logic            w_startFrame;
  logic            w_shiftBit;
  logic            w_frameLast;
  logic            w_countEn;
  logic            w_abort;
  logic            w_timeoutExpired;

  logic [3:0]      r_bitCnt;
  logic [9:0]      r_shift;
  logic [TO_W-1:0] r_timeout;
  logic            r_frameDone;
  logic            r_timeoutErr;

  logic            w_stopOk;
  logic            w_parityOk;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [7:0]      w_dout;

  logic            r_ready;
  logic [7:0]      r_data;

  // Two-flop synchronisers on both pins, plus one history flop on the
  // clock so that a falling edge can be seen. All flops reset high because
  // an idle PS/2 line is high. This keeps reset release from looking like
  // an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clkSync  <= 2'b11;
      r_dataSync <= 2'b11;
      r_clkHist  <= 1'b1;
    end else begin
      r_clkSync  <= {r_clkSync[0], ps2_clk};
      r_dataSync <= {r_dataSync[0], ps2_data};
      r_clkHist  <= r_clkSync[1];
    end
  end

  assign w_fall    = r_clkHist & ~r_clkSync[1];
  assign w_dataBit = r_dataSync[1];

  // The timeout compares against the last count value. The abort then lands
  // in the same edge where the count would have reached TIMEOUT_CYCLES.
  assign w_timeoutExpired = (r_timeout == TO_LAST);

  // Receive FSM: state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Receive FSM: next state. A high bit on a fall while idle is line noise
  // and is ignored. The 11th fall and a timeout both end the frame.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      RX_IDLE: begin
        if (w_fall && !w_dataBit) begin
          w_nextState = RX_RECV;
        end
      end
      RX_RECV: begin
        if (w_fall && (r_bitCnt == LAST_BIT)) begin
          w_nextState = RX_IDLE;
        end else if (!w_fall && w_timeoutExpired) begin
          w_nextState = RX_IDLE;
        end
      end
      default: w_nextState = RX_IDLE;
    endcase
  end

  // Receive FSM: control outputs that drive the datapath registers below.
  always_comb begin
    w_startFrame = 1'b0;
    w_shiftBit   = 1'b0;
    w_frameLast  = 1'b0;
    w_countEn    = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_startFrame = w_fall & ~w_dataBit;
      end
      RX_RECV: begin
        if (w_fall) begin
          w_shiftBit  = 1'b1;
          w_frameLast = (r_bitCnt == LAST_BIT);
        end else begin
          w_countEn = 1'b1;
          w_abort   = w_timeoutExpired;
        end
      end
      default: begin
        w_startFrame = 1'b0;
      end
    endcase
  end

  // Frame datapath. The start bit is only counted. The following ten bits
  // shift in from the top, so after the 11th fall the register holds
  // {stop, parity, d7..d0}. The partial contents left by an aborted frame
  // are fully overwritten by the next one. The two done flags make the
  // frame check and the timeout report happen one cycle after their cause.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bitCnt     <= '0;
      r_shift      <= '0;
      r_timeout    <= '0;
      r_frameDone  <= 1'b0;
      r_timeoutErr <= 1'b0;
    end else begin
      r_frameDone  <= w_frameLast;
      r_timeoutErr <= w_abort;
      if (w_startFrame) begin
        r_bitCnt <= 4'd1;
      end else if (w_frameLast || w_abort) begin
        r_bitCnt <= '0;
      end else if (w_shiftBit) begin
        r_bitCnt <= r_bitCnt + 4'd1;
      end
      if (w_shiftBit) begin
        r_shift <= {w_dataBit, r_shift[9:1]};
      end
      if (w_countEn && !w_abort) begin
        r_timeout <= r_timeout + 1'b1;
      end else begin
        r_timeout <= '0;
      end
    end
  end

  // Frame check in the cycle after the last fall. A bad stop bit hides any
  // parity problem, so each frame reports at most one error.
  assign w_stopOk   = r_shift[9];
  assign w_parityOk = oddParityOk(r_shift[8:0]);
  assign w_push     = r_frameDone & w_stopOk & w_parityOk;
  assign parity_err = r_frameDone & w_stopOk & ~w_parityOk;
  assign frame_err  = (r_frameDone & ~w_stopOk) | r_timeoutErr;

  // The FIFO refuses this exact condition, so this is the byte being lost.
  assign overflow = w_push & w_full & ~w_pop;

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (r_shift[7:0]),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Output stage. A pop is blocked while the strobe is high, so ready can
  // never be high in two consecutive cycles. There is no back-pressure from
  // the consumer.
  assign w_pop = ~w_empty & ~r_ready;

  // data keeps the last delivered byte between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ready <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      r_ready <= w_pop;
      if (w_pop) begin
        r_data <= w_dout;
      end
    end
  end

  assign ready = r_ready;
  assign data  = r_data;

endmodule

// File: tb/tb_ps2_receiver.sv
// ---------------------------------------------------------------------------
// tb_ps2_receiver
//
// Directed and randomised PS/2 frames are driven onto the pins. A monitor
// records every strobe and pulse at the falling clk edge, and the main
// sequence compares those records against expectations that are built from
// the frame rules: start 0, LSB-first data, odd parity, stop 1. Timing
// expectations are counted from the clk cycle in which the bench lowered
// ps2_clk.
// ---------------------------------------------------------------------------
module tb_ps2_receiver;
  import ps2_pkg::*;

  localparam int T = 2000;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ready;
  logic [7:0] data;
  logic       overflow;
  logic       parity_err;
  logic       frame_err;

  int nAsserts = 0;
  int nFail    = 0;
  int cyc      = 0;
  int lastFall = 0;

  logic [7:0] gotQ[$];
  int         gotCyc[$];
  logic [7:0] expQ[$];
  int         parCnt, frmCnt, ovCnt, b2bCnt;
  int         parCyc, frmCyc, ovCyc;
  bit         monMute  = 1'b0;
  bit         prevReady = 1'b0;

  ps2_receiver #(
    .FIFO_DEPTH     (8),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ready      (ready),
    .data       (data),
    .overflow   (overflow),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  // 100 MHz system clock.
  always #5 clk = ~clk;

  // Number of rising edges seen so far. A value read at a falling edge
  // names the cycle that is in progress.
  always @(posedge clk) cyc++;

  // Record strobes and pulses at the falling edge, away from the active
  // edge. The ready record can be muted while the bench holds the strobe.
  always @(negedge clk) begin
    if (!rst) begin
      prevReady = 1'b0;
    end else begin
      if (ready && !monMute) begin
        gotQ.push_back(data);
        gotCyc.push_back(cyc);
        if (prevReady) b2bCnt++;
      end
      prevReady = ready && !monMute;
      if (parity_err) begin parCnt++; parCyc = cyc; end
      if (frame_err)  begin frmCnt++; frmCyc = cyc; end
      if (overflow)   begin ovCnt++;  ovCyc  = cyc; end
    end
  end

  task automatic clearMon();
    gotQ.delete();
    gotCyc.delete();
    parCnt = 0; frmCnt = 0; ovCnt = 0; b2bCnt = 0;
    parCyc = -1; frmCyc = -1; ovCyc = -1;
  endtask

  function automatic logic [31:0] gotAt(int i);
    return (i < gotQ.size()) ? 32'(gotQ[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic int gotCycAt(int i);
    return (i < gotCyc.size()) ? gotCyc[i] : -1000;
  endfunction

  // Builds the 11-bit frame, bit 0 sent first. The parity bit is 1 when the
  // byte has an even number of ones.
  function automatic logic [10:0] makeFrame(input logic [7:0] b, input bit flipPar,
                                            input bit badStop);
    logic par;
    par = (($countones(b) % 2) == 0);
    if (flipPar) par = ~par;
    return {~badStop, par, b, 1'b0};
  endfunction

  // Sends the first nbits of a frame. Data changes while ps2_clk is high,
  // ps2_clk falls half cycles later, and the line is left idle high.
  task automatic applyStimulus(input logic [10:0] frame, input int nbits, input int half);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      repeat (half) @(negedge clk);
      ps2_clk  = 1'b0;
      lastFall = cyc;
      repeat (half) @(negedge clk);
      ps2_clk  = 1'b1;
    end
    repeat (half) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] b;
    int         kind, half, c, expPar, expFrm;
    bit         fp, bs;

    // Reset values.
    clearMon();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready",      32'(ready),      0);
    checkOutput("reset_data",       32'(data),       0);
    checkOutput("reset_overflow",   32'(overflow),   0);
    checkOutput("reset_parity_err", 32'(parity_err), 0);
    checkOutput("reset_frame_err",  32'(frame_err),  0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Single frame. The stop edge is detected 2 cycles after the pin falls,
    // and ready follows 3 cycles after that.
    $display("[TB] single frame");
    clearMon();
    applyStimulus(makeFrame(8'h1C, 0, 0), PS2_FRAME_BITS, 6);
    c = lastFall;
    repeat (20) @(negedge clk);
    checkOutput("single_count",  32'(gotQ.size()), 1);
    checkOutput("single_data",   gotAt(0), 32'h1C);
    checkOutput("single_timing", 32'(gotCycAt(0)), 32'(c + 5));
    checkOutput("single_errs",   32'(parCnt + frmCnt + ovCnt), 0);

    // Make/break sequence.
    $display("[TB] make/break sequence");
    clearMon();
    applyStimulus(makeFrame(8'h1C, 0, 0), PS2_FRAME_BITS, 6);
    applyStimulus(makeFrame(PS2_BREAK_CODE, 0, 0), PS2_FRAME_BITS, 6);
    applyStimulus(makeFrame(8'h1C, 0, 0), PS2_FRAME_BITS, 6);
    repeat (20) @(negedge clk);
    checkOutput("mb_count", 32'(gotQ.size()), 3);
    checkOutput("mb_byte0", gotAt(0), 32'h1C);
    checkOutput("mb_byte1", gotAt(1), 32'hF0);
    checkOutput("mb_byte2", gotAt(2), 32'h1C);
    checkOutput("mb_b2b",   32'(b2bCnt), 0);

    // Bad parity, then bad stop, then a good frame.
    $display("[TB] bad frames");
    clearMon();
    applyStimulus(makeFrame(8'h29, 1, 0), PS2_FRAME_BITS, 6);
    c = lastFall;
    repeat (20) @(negedge clk);
    checkOutput("par_count", 32'(parCnt), 1);
    checkOutput("par_cycle", 32'(parCyc), 32'(c + 3));
    checkOutput("par_frm",   32'(frmCnt), 0);
    checkOutput("par_ready", 32'(gotQ.size()), 0);
    clearMon();
    applyStimulus(makeFrame(8'h45, 0, 1), PS2_FRAME_BITS, 7);
    c = lastFall;
    repeat (20) @(negedge clk);
    checkOutput("stop_count", 32'(frmCnt), 1);
    checkOutput("stop_cycle", 32'(frmCyc), 32'(c + 3));
    checkOutput("stop_par",   32'(parCnt), 0);
    checkOutput("stop_ready", 32'(gotQ.size()), 0);
    clearMon();
    applyStimulus(makeFrame(8'h5A, 0, 0), PS2_FRAME_BITS, 6);
    repeat (20) @(negedge clk);
    checkOutput("after_bad_count", 32'(gotQ.size()), 1);
    checkOutput("after_bad_data",  gotAt(0), 32'h5A);

    // Random frames against the rule-level reference.
    $display("[TB] random frames");
    clearMon();
    expQ.delete();
    expPar = 0;
    expFrm = 0;
    for (int n = 0; n < 24; n++) begin
      b    = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 9);
      half = $urandom_range(5, 9);
      fp   = (kind == 0) || (kind == 2);
      bs   = (kind == 1) || (kind == 2);
      if (bs)      expFrm++;
      else if (fp) expPar++;
      else         expQ.push_back(b);
      applyStimulus(makeFrame(b, fp, bs), PS2_FRAME_BITS, half);
    end
    repeat (20) @(negedge clk);
    checkOutput("rand_count", 32'(gotQ.size()), 32'(expQ.size()));
    checkOutput("rand_par",   32'(parCnt), 32'(expPar));
    checkOutput("rand_frm",   32'(frmCnt), 32'(expFrm));
    checkOutput("rand_ovf",   32'(ovCnt), 0);
    checkOutput("rand_b2b",   32'(b2bCnt), 0);
    for (int i = 0; i < expQ.size(); i++) begin
      checkOutput($sformatf("rand_byte%0d", i), gotAt(i), 32'(expQ[i]));
    end

    // Overflow: hold the strobe high so nothing drains, then send nine bytes.
    $display("[TB] overflow");
    clearMon();
    expQ.delete();
    monMute = 1'b1;
    force dut.r_ready = 1'b1;
    for (int n = 0; n < 9; n++) begin
      b = 8'($urandom_range(0, 255));
      if (n < 8) expQ.push_back(b);
      applyStimulus(makeFrame(b, 0, 0), PS2_FRAME_BITS, 6);
    end
    c = lastFall;
    repeat (10) @(negedge clk);
    checkOutput("ovf_count", 32'(ovCnt), 1);
    checkOutput("ovf_cycle", 32'(ovCyc), 32'(c + 3));
    checkOutput("ovf_errs",  32'(parCnt + frmCnt), 0);
    release dut.r_ready;
    @(posedge clk);
    #1 monMute = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("drain_count", 32'(gotQ.size()), 8);
    checkOutput("drain_b2b",   32'(b2bCnt), 0);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("drain_byte%0d", i), gotAt(i), 32'(expQ[i]));
    end
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("drain_gap%0d", i), 32'(gotCycAt(i + 1) - gotCycAt(i)), 2);
    end

    // Timeout after 5 bits, then a good frame is received normally.
    $display("[TB] timeout");
    clearMon();
    applyStimulus(makeFrame(8'hA5, 0, 0), 5, 6);
    c = lastFall;
    repeat (T + 20) @(negedge clk);
    checkOutput("to_count", 32'(frmCnt), 1);
    checkOutput("to_cycle", 32'(frmCyc), 32'(c + T + 3));
    checkOutput("to_par",   32'(parCnt), 0);
    checkOutput("to_ready", 32'(gotQ.size()), 0);
    applyStimulus(makeFrame(8'h77, 0, 0), PS2_FRAME_BITS, 6);
    repeat (20) @(negedge clk);
    checkOutput("to_next_count", 32'(gotQ.size()), 1);
    checkOutput("to_next_data",  gotAt(0), 32'h77);
    checkOutput("to_next_frm",   32'(frmCnt), 1);

    // Reset mid-frame with three bytes queued.
    $display("[TB] reset mid-frame");
    clearMon();
    monMute = 1'b1;
    force dut.r_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      applyStimulus(makeFrame(8'(8'h30 + n), 0, 0), PS2_FRAME_BITS, 6);
    end
    applyStimulus(makeFrame(8'h66, 0, 0), 3, 6);
    rst = 1'b0;
    release dut.r_ready;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready",      32'(ready),      0);
    checkOutput("rst_data",       32'(data),       0);
    checkOutput("rst_overflow",   32'(overflow),   0);
    checkOutput("rst_parity_err", 32'(parity_err), 0);
    checkOutput("rst_frame_err",  32'(frame_err),  0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    clearMon();
    monMute = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("post_rst_ready", 32'(gotQ.size()), 0);
    checkOutput("post_rst_errs",  32'(parCnt + frmCnt + ovCnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
